// File: rtl/lex_token_stage_if.sv
// Stream bundle for the lexer stage.
//   Character side : in_valid, in_char, in_last (towards the lexer), in_ready (from the lexer)
//   Token side     : tok_valid, tok_type, tok_value, tok_len, tok_line, tok_col (from the lexer),
//                    tok_ready (towards the lexer)
// Modports:
//   master - the lexer stage itself (produces tokens, consumes characters)
//   slave  - the surrounding environment (character source and token sink)
interface lex_token_stage_if #(
    parameter int VAL_W  = 32,
    parameter int LINE_W = 16,
    parameter int COL_W  = 16,
    parameter int LEN_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_char;
    logic              in_last;
    logic              tok_valid;
    logic              tok_ready;
    logic [2:0]        tok_type;
    logic [VAL_W-1:0]  tok_value;
    logic [LEN_W-1:0]  tok_len;
    logic [LINE_W-1:0] tok_line;
    logic [COL_W-1:0]  tok_col;

    modport master (
        input  in_valid, in_char, in_last, tok_ready,
        output in_ready, tok_valid, tok_type, tok_value, tok_len, tok_line, tok_col
    );

    modport slave (
        output in_valid, in_char, in_last, tok_ready,
        input  in_ready, tok_valid, tok_type, tok_value, tok_len, tok_line, tok_col
    );
endinterface

// File: rtl/lex_token_stage.sv
// Byte-per-cycle tokenizer: classifies the character stream into NUM / IDENT / STR /
// PUNC / OP / EOF / ERR tokens with the line/column of each token's first character.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - lex_token_stage_if.master (character input stream + token output stream)
//   busy_o    - FSM not idle, or a token is waiting in the output register
// Build option: define COMMENT_SKIP_EN to skip '#' comments up to and including '\n';
// without it '#' is reported as an ERR token.
// VAL_W must be at least 32 so the first four characters can be packed into the value.
module lex_token_stage #(
    parameter int VAL_W  = 32,
    parameter int LINE_W = 16,
    parameter int COL_W  = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    lex_token_stage_if.master bus,
    output logic              busy_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_NUM, S_IDENT, S_STR, S_ESC, S_OP
`ifdef COMMENT_SKIP_EN
        , S_CMT
`endif
    } state_t;

    localparam logic [2:0] T_NONE  = 3'd0;
    localparam logic [2:0] T_NUM   = 3'd1;
    localparam logic [2:0] T_IDENT = 3'd2;
    localparam logic [2:0] T_STR   = 3'd3;
    localparam logic [2:0] T_PUNC  = 3'd4;
    localparam logic [2:0] T_OP    = 3'd5;
    localparam logic [2:0] T_EOF   = 3'd6;
    localparam logic [2:0] T_ERR   = 3'd7;

    localparam logic [VAL_W+3:0]  TEN      = (VAL_W+4)'(10);
    localparam logic [VAL_W-1:0]  VAL_MAX  = {VAL_W{1'b1}};
    localparam logic [LEN_W-1:0]  LEN_MAX  = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_TWO  = LEN_W'(2);
    localparam logic [LINE_W-1:0] LINE_ONE = {{(LINE_W-1){1'b0}}, 1'b1};
    localparam logic [COL_W-1:0]  COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};

    function automatic logic is_ws(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h09) || (c == 8'h0D) || (c == 8'h0A);
    endfunction

    function automatic logic is_dig(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_ids(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h5F);
    endfunction

    function automatic logic is_idc(input logic [7:0] c);
        return is_ids(c) || is_dig(c) || (c == 8'h3F) || (c == 8'h21) || (c == 8'h2D);
    endfunction

    function automatic logic is_punc(input logic [7:0] c);
        return (c == 8'h2C) || (c == 8'h3B) || (c == 8'h28) || (c == 8'h29) ||
               (c == 8'h7B) || (c == 8'h7D) || (c == 8'h5B) || (c == 8'h5D);
    endfunction

    function automatic logic is_opc(input logic [7:0] c);
        return (c == 8'h2B) || (c == 8'h2D) || (c == 8'h2A) || (c == 8'h2F) ||
               (c == 8'h25) || (c == 8'h3D) || (c == 8'h26) || (c == 8'h7C) ||
               (c == 8'h3C) || (c == 8'h3E) || (c == 8'h21);
    endfunction

    // Place character c into byte slot n of v; slots beyond the fourth are ignored.
    function automatic logic [VAL_W-1:0] pack_char(input logic [VAL_W-1:0] v,
                                                   input logic [LEN_W-1:0] n,
                                                   input logic [7:0] c);
        logic [VAL_W-1:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = (n == LEN_W'(i)) ? c : r[8*i +: 8];
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [VAL_W-1:0]  val_q, val_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LINE_W-1:0] line_q, line_d, sline_q, sline_d;
    logic [COL_W-1:0]  col_q, col_d, scol_q, scol_d;
    logic              eof_q, eof_d;
    logic              tv_q, tv_d;
    logic [2:0]        ttype_q, ttype_d;
    logic [VAL_W-1:0]  tval_q, tval_d;
    logic [LEN_W-1:0]  tlen_q, tlen_d;
    logic [LINE_W-1:0] tline_q, tline_d;
    logic [COL_W-1:0]  tcol_q, tcol_d;

    logic [7:0]        c_s;
    logic              can_load_s;
    logic              consume_s;
    logic              emit_s;
    logic [2:0]        etype_s;
    logic [VAL_W-1:0]  evalue_s;
    logic [LEN_W-1:0]  elen_s;
    logic [LINE_W-1:0] eline_s;
    logic [COL_W-1:0]  ecol_s;
    logic [LEN_W-1:0]  len_inc_s;
    logic [VAL_W+3:0]  num_wide_s;
    logic [VAL_W-1:0]  num_next_s;
    logic [VAL_W-1:0]  char_val_s;

    assign c_s        = bus.in_char;
    assign char_val_s = {{(VAL_W-8){1'b0}}, c_s};
    // Every consumed char may need the output register, so input stalls whenever it is held.
    assign can_load_s = !tv_q || bus.tok_ready;
    assign len_inc_s  = (len_q == LEN_MAX) ? len_q : len_q + LEN_ONE;
    // ASCII digits 0x30..0x39 carry their value in the low nibble.
    assign num_wide_s = ({4'b0000, val_q} * TEN) + {{VAL_W{1'b0}}, c_s[3:0]};
    assign num_next_s = (num_wide_s[VAL_W+3:VAL_W] != 4'b0000) ? VAL_MAX : num_wide_s[VAL_W-1:0];

    // Next-state, consume decision and token assembly.
    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        len_d    = len_q;
        line_d   = line_q;
        col_d    = col_q;
        sline_d  = sline_q;
        scol_d   = scol_q;
        eof_d    = eof_q;
        tv_d     = tv_q;
        ttype_d  = ttype_q;
        tval_d   = tval_q;
        tlen_d   = tlen_q;
        tline_d  = tline_q;
        tcol_d   = tcol_q;
        consume_s = 1'b0;
        emit_s    = 1'b0;
        etype_s   = T_NONE;
        evalue_s  = char_val_s;
        elen_s    = LEN_ONE;
        eline_s   = line_q;
        ecol_s    = col_q;

        if (!can_load_s) begin
            consume_s = 1'b0;
        end else if (eof_q) begin
            // End-of-stream flush: open token (or unterminated string) first, then EOF.
            state_d = S_IDLE;
            emit_s  = 1'b1;
            eline_s = sline_q;
            ecol_s  = scol_q;
            evalue_s = val_q;
            elen_s   = len_q;
            case (state_q)
                S_NUM:   etype_s = T_NUM;
                S_IDENT: etype_s = T_IDENT;
                S_OP:    etype_s = T_OP;
                S_STR, S_ESC: begin
                    etype_s  = T_ERR;
                    evalue_s = {{(VAL_W-8){1'b0}}, 8'h22};
                    elen_s   = LEN_ONE;
                end
                default: begin
                    etype_s  = T_EOF;
                    evalue_s = {VAL_W{1'b0}};
                    elen_s   = {LEN_W{1'b0}};
                    eline_s  = line_q;
                    ecol_s   = col_q;
                    line_d   = {LINE_W{1'b0}};
                    col_d    = {COL_W{1'b0}};
                    eof_d    = 1'b0;
                end
            endcase
        end else if (bus.in_valid) begin
            consume_s = 1'b1;
            case (state_q)
                S_IDLE: begin
                    sline_d = line_q;
                    scol_d  = col_q;
                    if (is_ws(c_s)) begin
                        state_d = S_IDLE;
                    end else if (is_dig(c_s)) begin
                        state_d = S_NUM;
                        val_d   = {{(VAL_W-4){1'b0}}, c_s[3:0]};
                        len_d   = LEN_ONE;
                    end else if (is_ids(c_s)) begin
                        state_d = S_IDENT;
                        val_d   = char_val_s;
                        len_d   = LEN_ONE;
                    end else if (c_s == 8'h22) begin
                        state_d = S_STR;
                        val_d   = {VAL_W{1'b0}};
                        len_d   = {LEN_W{1'b0}};
                    end else if (is_punc(c_s)) begin
                        emit_s  = 1'b1;
                        etype_s = T_PUNC;
                    end else if (is_opc(c_s)) begin
                        state_d = S_OP;
                        val_d   = char_val_s;
                        len_d   = LEN_ONE;
`ifdef COMMENT_SKIP_EN
                    end else if (c_s == 8'h23) begin
                        state_d = S_CMT;
`endif
                    end else begin
                        emit_s  = 1'b1;
                        etype_s = T_ERR;
                    end
                end
                S_NUM, S_IDENT, S_OP: begin
                    if ((state_q == S_NUM) && is_dig(c_s)) begin
                        val_d = num_next_s;
                        len_d = len_inc_s;
                    end else if ((state_q == S_IDENT) && is_idc(c_s)) begin
                        val_d = pack_char(val_q, len_q, c_s);
                        len_d = len_inc_s;
                    end else if ((state_q == S_OP) && is_opc(c_s) && (len_q < LEN_TWO)) begin
                        val_d = pack_char(val_q, len_q, c_s);
                        len_d = len_inc_s;
                    end else begin
                        // Terminator is only peeked; IDLE re-examines it next cycle.
                        consume_s = 1'b0;
                        emit_s    = 1'b1;
                        etype_s   = (state_q == S_NUM) ? T_NUM : ((state_q == S_IDENT) ? T_IDENT : T_OP);
                        evalue_s  = val_q;
                        elen_s    = len_q;
                        eline_s   = sline_q;
                        ecol_s    = scol_q;
                        state_d   = S_IDLE;
                    end
                end
                S_STR: begin
                    if (c_s == 8'h5C) begin
                        state_d = S_ESC;
                    end else if (c_s == 8'h22) begin
                        emit_s   = 1'b1;
                        etype_s  = T_STR;
                        evalue_s = val_q;
                        elen_s   = len_q;
                        eline_s  = sline_q;
                        ecol_s   = scol_q;
                        state_d  = S_IDLE;
                    end else begin
                        val_d = pack_char(val_q, len_q, c_s);
                        len_d = len_inc_s;
                    end
                end
                S_ESC: begin
                    val_d   = pack_char(val_q, len_q, c_s);
                    len_d   = len_inc_s;
                    state_d = S_STR;
                end
`ifdef COMMENT_SKIP_EN
                S_CMT: begin
                    state_d = (c_s == 8'h0A) ? S_IDLE : S_CMT;
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            consume_s = 1'b0;
        end

        if (consume_s) begin
            if (c_s == 8'h0A) begin
                line_d = line_q + LINE_ONE;
                col_d  = {COL_W{1'b0}};
            end else begin
                col_d = col_q + COL_ONE;
            end
            eof_d = bus.in_last ? 1'b1 : eof_q;
        end else begin
            eof_d = eof_d;
        end

        if (can_load_s) begin
            tv_d = emit_s;
            if (emit_s) begin
                ttype_d = etype_s;
                tval_d  = evalue_s;
                tlen_d  = elen_s;
                tline_d = eline_s;
                tcol_d  = ecol_s;
            end else begin
                ttype_d = ttype_q;
            end
        end else begin
            tv_d = tv_q;
        end
    end

    // State, position, accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            val_q   <= {VAL_W{1'b0}};
            len_q   <= {LEN_W{1'b0}};
            line_q  <= {LINE_W{1'b0}};
            col_q   <= {COL_W{1'b0}};
            sline_q <= {LINE_W{1'b0}};
            scol_q  <= {COL_W{1'b0}};
            eof_q   <= 1'b0;
            tv_q    <= 1'b0;
            ttype_q <= T_NONE;
            tval_q  <= {VAL_W{1'b0}};
            tlen_q  <= {LEN_W{1'b0}};
            tline_q <= {LINE_W{1'b0}};
            tcol_q  <= {COL_W{1'b0}};
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            len_q   <= len_d;
            line_q  <= line_d;
            col_q   <= col_d;
            sline_q <= sline_d;
            scol_q  <= scol_d;
            eof_q   <= eof_d;
            tv_q    <= tv_d;
            ttype_q <= ttype_d;
            tval_q  <= tval_d;
            tlen_q  <= tlen_d;
            tline_q <= tline_d;
            tcol_q  <= tcol_d;
        end
    end

    assign bus.in_ready  = consume_s;
    assign bus.tok_valid = tv_q;
    assign bus.tok_type  = ttype_q;
    assign bus.tok_value = tval_q;
    assign bus.tok_len   = tlen_q;
    assign bus.tok_line  = tline_q;
    assign bus.tok_col   = tcol_q;
    assign busy_o        = (state_q != S_IDLE) || tv_q;
endmodule

// File: tb/tb_lex_token_stage.sv
// Self-checking bench for lex_token_stage: directed streams plus randomized streams,
// compared against a string-scanning reference lexer.
module tb_lex_token_stage;
    localparam int VAL_W  = 32;
    localparam int LINE_W = 16;
    localparam int COL_W  = 16;
    localparam int LEN_W  = 8;

    typedef logic [7:0] ch_t;
    typedef struct packed {
        logic [2:0]  typ;
        logic [31:0] val;
        logic [7:0]  len;
        logic [15:0] line;
        logic [15:0] col;
    } tok_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    lex_token_stage_if #(.VAL_W(VAL_W), .LINE_W(LINE_W), .COL_W(COL_W), .LEN_W(LEN_W)) bus ();

    lex_token_stage #(.VAL_W(VAL_W), .LINE_W(LINE_W), .COL_W(COL_W), .LEN_W(LEN_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy_o (busy)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference lexer ----------------
    function automatic bit m_ws(input ch_t c);
        return c == " " || c == 8'h09 || c == 8'h0D || c == 8'h0A;
    endfunction
    function automatic bit m_dig(input ch_t c);
        return c >= "0" && c <= "9";
    endfunction
    function automatic bit m_ids(input ch_t c);
        return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z") || c == "_";
    endfunction
    function automatic bit m_idc(input ch_t c);
        return m_ids(c) || m_dig(c) || c == "?" || c == "!" || c == "-";
    endfunction
    function automatic bit m_punc(input ch_t c);
        return c == "," || c == ";" || c == "(" || c == ")" || c == "{" || c == "}" || c == "[" || c == "]";
    endfunction
    function automatic bit m_opc(input ch_t c);
        return c == "+" || c == "-" || c == "*" || c == "/" || c == "%" || c == "=" ||
               c == "&" || c == "|" || c == "<" || c == ">" || c == "!";
    endfunction

    function automatic void adv(inout int line, inout int col, input ch_t c);
        if (c == 8'h0A) begin
            line = (line + 1) % 65536;
            col  = 0;
        end else begin
            col = (col + 1) % 65536;
        end
    endfunction

    function automatic tok_t mk(input int typ, input longint val, input int len, input int line, input int col);
        tok_t t;
        t.typ  = typ[2:0];
        t.val  = val[31:0];
        t.len  = (len > 255) ? 8'd255 : len[7:0];
        t.line = line[15:0];
        t.col  = col[15:0];
        return t;
    endfunction

    function automatic void lex_model(input ch_t s[$], output tok_t out[$]);
        int i, n, line, col, sl, sc, k;
        longint v;
        ch_t c;
        bit closed;
        out = {};
        i = 0; n = s.size(); line = 0; col = 0;
        while (i < n) begin
            c = s[i]; sl = line; sc = col;
            if (m_ws(c)) begin
                adv(line, col, c); i++;
            end else if (m_dig(c)) begin
                v = 0; k = 0;
                while (i < n && m_dig(s[i])) begin
                    v = v * 10 + (s[i] - 8'h30);
                    if (v > 64'd4294967295) v = 64'd4294967295;
                    k++; adv(line, col, s[i]); i++;
                end
                out.push_back(mk(1, v, k, sl, sc));
            end else if (m_ids(c)) begin
                v = 0; k = 0;
                while (i < n && m_idc(s[i])) begin
                    if (k < 4) v = v | (longint'(s[i]) << (8 * k));
                    k++; adv(line, col, s[i]); i++;
                end
                out.push_back(mk(2, v, k, sl, sc));
            end else if (c == 8'h22) begin
                adv(line, col, c); i++;
                v = 0; k = 0; closed = 0;
                while (i < n && !closed) begin
                    c = s[i]; adv(line, col, c); i++;
                    if (c == 8'h22) begin
                        closed = 1;
                    end else begin
                        if (c == 8'h5C) begin
                            if (i >= n) break;
                            c = s[i]; adv(line, col, c); i++;
                        end
                        if (k < 4) v = v | (longint'(c) << (8 * k));
                        k++;
                    end
                end
                if (closed) out.push_back(mk(3, v, k, sl, sc));
                else        out.push_back(mk(7, 64'h22, 1, sl, sc));
            end else if (m_punc(c)) begin
                out.push_back(mk(4, longint'(c), 1, sl, sc));
                adv(line, col, c); i++;
            end else if (m_opc(c)) begin
                v = longint'(c); k = 1; adv(line, col, c); i++;
                if (i < n && m_opc(s[i])) begin
                    v = v | (longint'(s[i]) << 8); k = 2; adv(line, col, s[i]); i++;
                end
                out.push_back(mk(5, v, k, sl, sc));
`ifdef COMMENT_SKIP_EN
            end else if (c == 8'h23) begin
                closed = 0;
                while (i < n && !closed) begin
                    c = s[i]; adv(line, col, c); i++;
                    closed = (c == 8'h0A);
                end
`endif
            end else begin
                out.push_back(mk(7, longint'(c), 1, sl, sc));
                adv(line, col, c); i++;
            end
        end
        out.push_back(mk(6, 0, 0, line, col));
    endfunction

    function automatic void to_q(input string str, output ch_t q[$]);
        q = {};
        for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
    endfunction

    // ---------------- stream driver / token collector ----------------
    task automatic drive(input ch_t s[$], input bit gaps);
        int guard;
        for (int i = 0; i < s.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_char  = s[i];
            bus.in_last  = (i == s.size() - 1);
            guard = 0;
            @(negedge clk);
            while (!bus.in_ready && guard < 300) begin
                guard++;
                @(negedge clk);
            end
            if (!bus.in_ready) begin
                check("in_ready_wait", 80'(bus.in_ready), 80'(1));
                break;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // mode 0: tok_ready high; 1: random tok_ready; 2: hold first token for 5 cycles
    task automatic collect(input tok_t exp[$], input int mode, output tok_t got[$]);
        int   idx, cyc, stall_cnt;
        bit   done, prev_stall;
        tok_t cur, prev, e, cm, snap;
        got = {}; idx = 0; cyc = 0; stall_cnt = 0; done = 0; prev_stall = 0;
        prev = '0; snap = '0;
        while (!done && cyc < 3000) begin
            case (mode)
                0:       bus.tok_ready = 1'b1;
                1:       bus.tok_ready = ($urandom_range(0, 3) != 0);
                default: bus.tok_ready = (stall_cnt >= 5);
            endcase
            @(negedge clk);
            cyc++;
            cur.typ  = bus.tok_type;
            cur.val  = bus.tok_value;
            cur.len  = bus.tok_len;
            cur.line = bus.tok_line;
            cur.col  = bus.tok_col;
            if (prev_stall) check("stall_stable", 80'({bus.tok_valid, cur}), 80'({1'b1, prev}));
            if (bus.tok_valid && bus.tok_ready) begin
                got.push_back(cur);
                if (idx < exp.size()) begin
                    e = exp[idx]; cm = cur;
                    if (e.typ == 3'd7) begin
                        e.len = 8'd0; cm.len = 8'd0;
                    end
                    check($sformatf("tok%0d", idx), 80'(cm), 80'(e));
                end else begin
                    check("extra_tok", 80'(cur), 80'(0));
                end
                idx++;
                if (cur.typ == 3'd6) done = 1;
            end else if (bus.tok_valid && mode == 2 && stall_cnt < 5) begin
                check("stall_in_ready", 80'(bus.in_ready), 80'(0));
                if (stall_cnt > 0) check("stall_fields", 80'(cur), 80'(snap));
                else               snap = cur;
                stall_cnt++;
            end
            prev_stall = bus.tok_valid && !bus.tok_ready;
            prev = cur;
            @(posedge clk); #1;
        end
        if (!done) check("eof_timeout", 80'(done), 80'(1));
        check("tok_count", 80'(idx), 80'(exp.size()));
        bus.tok_ready = 1'b1;
    endtask

    task automatic run_q(input ch_t s[$], input int mode, output tok_t got[$]);
        tok_t exp[$];
        lex_model(s, exp);
        fork
            drive(s, mode == 1);
            collect(exp, mode, got);
        join
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_str(input string str, input int mode, output tok_t got[$]);
        ch_t s[$];
        to_q(str, s);
        run_q(s, mode, got);
    endtask

    initial begin
        tok_t  got[$];
        ch_t   s[$];
        string alpha;
        alpha = "ab_Zq09 7\n\t+-=<!\",;(){}#\\?@$";
        bus.in_valid  = 1'b0;
        bus.in_char   = 8'h00;
        bus.in_last   = 1'b0;
        bus.tok_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 80'(bus.tok_valid), 80'(0));
        check("rst_fields", 80'({bus.tok_type, bus.tok_value, bus.tok_len, bus.tok_line, bus.tok_col}), 80'(0));
        check("rst_busy", 80'(busy), 80'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_str("ab1 42;", 0, got);
        check("t1_ident_val", 80'(got[0].val), 80'(32'h00316261));
        check("t1_ident_len", 80'(got[0].len), 80'(3));
        check("t1_num_val", 80'(got[1].val), 80'(42));
        check("t1_num_col", 80'(got[1].col), 80'(4));
        check("t1_punc_val", 80'(got[2].val), 80'(32'h3B));
        check("t1_eof_col", 80'({got[3].typ, got[3].col}), 80'({3'd6, 16'd7}));

        run_str("x==y", 0, got);
        check("t2_op", 80'({got[1].typ, got[1].val, got[1].len, got[1].col}), 80'({3'd5, 32'h3D3D, 8'd2, 16'd1}));
        check("t2_ident_y", 80'({got[2].val, got[2].col}), 80'({32'h79, 16'd3}));

        run_str("\"a\\\"b\"", 0, got);
        check("t3_str", 80'({got[0].typ, got[0].val, got[0].len}), 80'({3'd3, 32'h00622261, 8'd3}));
        check("t3_eof", 80'(got[1].typ), 80'(6));

        run_str("99999999999 ", 0, got);
        check("t4_sat", 80'({got[0].typ, got[0].val, got[0].len}), 80'({3'd1, 32'hFFFFFFFF, 8'd11}));

        run_str("# hi\n7", 0, got);
`ifdef COMMENT_SKIP_EN
        check("t5_num", 80'({got[0].typ, got[0].val, got[0].line, got[0].col}), 80'({3'd1, 32'd7, 16'd1, 16'd0}));
        check("t5_eof", 80'({got[1].typ, got[1].line, got[1].col}), 80'({3'd6, 16'd1, 16'd1}));
`else
        check("t5_err", 80'({got[0].typ, got[0].val, got[0].line, got[0].col}), 80'({3'd7, 32'h23, 16'd0, 16'd0}));
`endif

        run_str("12+3", 2, got);
        check("t6_num", 80'({got[0].typ, got[0].val}), 80'({3'd1, 32'd12}));

        // reset in the middle of an open string
        to_q("\"abc", s);
        bus.tok_ready = 1'b1;
        foreach (s[i]) begin
            bus.in_valid = 1'b1;
            bus.in_char  = s[i];
            bus.in_last  = 1'b0;
            @(negedge clk);
            check("t7_ready", 80'({bus.in_ready, bus.tok_valid}), 80'({1'b1, 1'b0}));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t7_busy", 80'(busy), 80'(1));
        rst = 1'b1;
        #1;
        check("t7_rst_out", 80'({bus.tok_valid, bus.tok_type, bus.tok_value, bus.tok_len, bus.tok_line, bus.tok_col, busy}), 80'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t7_no_tok", 80'({bus.tok_valid, busy}), 80'(0));
        end
        @(posedge clk); #1;
        run_str("ab1 42;", 0, got);
        check("t8_restart", 80'({got[0].typ, got[0].line, got[0].col}), 80'({3'd2, 16'd0, 16'd0}));

        for (int r = 0; r < 20; r++) begin
            s = {};
            repeat ($urandom_range(4, 24)) s.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
            run_q(s, 1, got);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
